// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staggered power-on reset sequencer: FSM state
// encoding and a constant-evaluable clog2 used for parameter sanity checks.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
    function automatic int clog2(input longint unsigned value);
        longint unsigned v;
        int              r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Saturating up-counter for the reset sequencer, with synchronous clear,
// count enable and a registered-count ">= limit" flag.
module rst_seq_timer
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);
    import reset_seq_pkg::*;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable; the count sticks at all-ones rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q >= limit);

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset generator with NUM_CH active-low channels released one by one.
// Optional re-run input 'trigger' is compiled in with RST_SEQ_TRIGGER_EN.
module reset_sequencer
#(
    parameter int INITIAL_US_DELAY = 1000000,
    parameter int CLOCK_SPEED_HZ   = 50000000,
    parameter int PULSE_LENGTH     = 100,
    parameter int NUM_CH           = 4,
    parameter int STAGGER_CYCLES   = 16,
    parameter int CNT_W            = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef RST_SEQ_TRIGGER_EN
    input  logic              trigger,
`endif
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              busy,
    output logic              done
);
    import reset_seq_pkg::*;

    localparam longint unsigned INIT_CYCLES_L =
        longint'(CLOCK_SPEED_HZ / 1000000) * longint'(INITIAL_US_DELAY);
    localparam longint unsigned LAST_REL_L =
        longint'(PULSE_LENGTH) + longint'(NUM_CH - 1) * longint'(STAGGER_CYCLES);

    localparam logic [CNT_W-1:0] INIT_CYCLES = CNT_W'(INIT_CYCLES_L);
    localparam logic [CNT_W-1:0] LAST_REL_M1 = CNT_W'(LAST_REL_L - 64'd1);

    if (PULSE_LENGTH < 1) begin : g_bad_pulse
        $error("reset_sequencer: PULSE_LENGTH must be >= 1");
    end
    if ((NUM_CH < 1) || (NUM_CH > 32)) begin : g_bad_num_ch
        $error("reset_sequencer: NUM_CH must be in 1..32");
    end
    if ((clog2(INIT_CYCLES_L + 64'd1) > CNT_W) || (clog2(LAST_REL_L + 64'd1) > CNT_W)) begin : g_bad_cnt_w
        $error("reset_sequencer: CNT_W too narrow for the configured delays");
    end

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [NUM_CH-1:0] ch_rst_n_q;
    logic [NUM_CH-1:0] ch_rst_n_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;

    logic              trig_req;
    logic              tmr_clear;
    logic              tmr_enable;
    logic [CNT_W-1:0]  tmr_limit;
    logic [CNT_W-1:0]  tmr_count;
    logic              tmr_at_limit;
    logic [NUM_CH-1:0] rel_hit;

`ifdef RST_SEQ_TRIGGER_EN
    assign trig_req = trigger;
`else
    assign trig_req = 1'b0;
`endif

    rst_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clear),
        .enable   (tmr_enable),
        .limit    (tmr_limit),
        .count    (tmr_count),
        .at_limit (tmr_at_limit)
    );

    // The timer is cleared on entry to ASSERT, so at the m-th edge after entry
    // it reads m-1; channel i releases when m = PULSE_LENGTH + i*STAGGER_CYCLES.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rel
        localparam logic [CNT_W-1:0] REL_M1 = CNT_W'(
            longint'(PULSE_LENGTH) - 64'sd1 + longint'(gi) * longint'(STAGGER_CYCLES));
        assign rel_hit[gi] = (tmr_count >= REL_M1);
    end

    always_comb begin
        state_d    = state_q;
        ch_rst_n_d = ch_rst_n_q;
        busy_d     = busy_q;
        done_d     = done_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        tmr_limit  = (state_q == ST_WAIT) ? INIT_CYCLES : LAST_REL_M1;

        case (state_q)
            ST_WAIT: begin
                tmr_enable = 1'b1;
                if (tmr_at_limit) begin
                    state_d    = ST_ASSERT;
                    ch_rst_n_d = '0;
                    tmr_clear  = 1'b1;
                end
            end

            ST_ASSERT, ST_RELEASE: begin
                tmr_enable = 1'b1;
                ch_rst_n_d = ch_rst_n_q | rel_hit;
                if (tmr_at_limit) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (rel_hit[0]) begin
                    state_d = ST_RELEASE;
                end
            end

            ST_DONE: begin
                // Re-run skips the initial delay and goes straight to assertion.
                if (trig_req) begin
                    state_d    = ST_ASSERT;
                    ch_rst_n_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    tmr_clear  = 1'b1;
                end
            end

            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT;
            ch_rst_n_q <= '1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_rst_n_q <= ch_rst_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ch_rst_n = ch_rst_n_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (nominal and edge parameters) checked
// every cycle against a cycle-count reference model; trigger tests need RST_SEQ_TRIGGER_EN.
module tb_reset_sequencer;

  localparam int CLK_HZ = 10000000;
  localparam int PULSE  = 4;

`ifdef RST_SEQ_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger;
  logic [2:0] ch_a;
  logic       busy_a;
  logic       done_a;
  logic [0:0] ch_b;
  logic       busy_b;
  logic       done_b;

  always #5 clk = ~clk;

  reset_sequencer #(
    .INITIAL_US_DELAY (1),
    .CLOCK_SPEED_HZ   (CLK_HZ),
    .PULSE_LENGTH     (PULSE),
    .NUM_CH           (3),
    .STAGGER_CYCLES   (2),
    .CNT_W            (32)
  ) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef RST_SEQ_TRIGGER_EN
    .trigger  (trigger),
`endif
    .ch_rst_n (ch_a),
    .busy     (busy_a),
    .done     (done_a)
  );

  reset_sequencer #(
    .INITIAL_US_DELAY (0),
    .CLOCK_SPEED_HZ   (CLK_HZ),
    .PULSE_LENGTH     (PULSE),
    .NUM_CH           (1),
    .STAGGER_CYCLES   (0),
    .CNT_W            (32)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef RST_SEQ_TRIGGER_EN
    .trigger  (trigger),
`endif
    .ch_rst_n (ch_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  // Reference model, per instance: cycles since the sequence anchor and the
  // delay before assertion (INIT_CYCLES after power-on, 0 after a trigger).
  int m_init  [2] = '{10, 0};
  int m_nch   [2] = '{3, 1};
  int m_stag  [2] = '{2, 0};
  bit in_rst  [2] = '{1'b1, 1'b1};
  int rel     [2] = '{0, 0};
  int dly     [2] = '{0, 0};

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [31:0] exp_ch(input int d);
    logic [31:0] v;
    int          m;
    v = '0;
    m = rel[d] - dly[d];
    for (int i = 0; i < m_nch[d]; i++) begin
      v[i] = in_rst[d] || (m < 0) || (m >= PULSE + i * m_stag[d]);
    end
    return v;
  endfunction

  function automatic logic exp_done(input int d);
    int m;
    m = rel[d] - dly[d];
    return !in_rst[d] && (m >= PULSE + (m_nch[d] - 1) * m_stag[d]);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        in_rst[d] = 1'b1;
      end else if (in_rst[d]) begin
        in_rst[d] = 1'b0;
        rel[d]    = 0;
        dly[d]    = m_init[d];
      end else if (TRIG_EN && trigger && exp_done(d)) begin
        rel[d] = 0;
        dly[d] = 0;
      end else if (rel[d] < 1000000) begin
        rel[d] = rel[d] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    chk("a_ch",   32'(ch_a),   exp_ch(0));
    chk("a_done", 32'(done_a), 32'(exp_done(0)));
    chk("a_busy", 32'(busy_a), 32'(!exp_done(0)));
    chk("b_ch",   32'(ch_b),   exp_ch(1));
    chk("b_done", 32'(done_b), 32'(exp_done(1)));
    chk("b_busy", 32'(busy_b), 32'(!exp_done(1)));
  endtask

  task automatic step(input logic r, input logic t);
    rst_n   = r;
    trigger = t;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    repeat (3) step(1'b0, 1'b0);
  endtask

  // Power-on sequence from cycle 0 with literal expectations at the key cycles.
  task automatic power_on_spot();
    for (int k = 0; k < 25; k++) begin
      step(1'b1, 1'b0);
      case (k)
        3:  chk("b_c3_ch", 32'(ch_b), 32'd0);
        4:  begin chk("b_c4_ch", 32'(ch_b), 32'd1); chk("b_c4_done", 32'(done_b), 32'd1); end
        9:  chk("a_c9_ch", 32'(ch_a), 32'd7);
        10: chk("a_c10_ch", 32'(ch_a), 32'd0);
        13: chk("a_c13_ch", 32'(ch_a), 32'd0);
        14: chk("a_c14_ch", 32'(ch_a), 32'd1);
        16: chk("a_c16_ch", 32'(ch_a), 32'd3);
        17: begin chk("a_c17_busy", 32'(busy_a), 32'd1); chk("a_c17_done", 32'(done_a), 32'd0); end
        18: begin chk("a_c18_ch", 32'(ch_a), 32'd7); chk("a_c18_done", 32'(done_a), 32'd1); end
        default: ;
      endcase
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    trigger = 1'b0;

    // Power-on
    do_reset();
    chk("rst_a_ch", 32'(ch_a), 32'd7);
    chk("rst_a_busy", 32'(busy_a), 32'd1);
    chk("rst_b_ch", 32'(ch_b), 32'd1);
    power_on_spot();

    // Mid-sequence reset at cycle 15, then a full rerun
    do_reset();
    repeat (16) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("mid_rst_ch", 32'(ch_a), 32'd7);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    power_on_spot();

    // Random mid-sequence reset points
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 22)) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    repeat (25) step(1'b1, 1'b0);

`ifdef RST_SEQ_TRIGGER_EN
    // Trigger pulse at cycle 30, sampled at edge 31
    do_reset();
    repeat (31) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("trg_c31_ch", 32'(ch_a), 32'd0);
    chk("trg_c31_busy", 32'(busy_a), 32'd1);
    for (int k = 32; k < 42; k++) begin
      step(1'b1, 1'b0);
      if (k == 34) chk("trg_c34_ch", 32'(ch_a), 32'd0);
      if (k == 35) chk("trg_c35_ch", 32'(ch_a), 32'd1);
      if (k == 37) chk("trg_c37_ch", 32'(ch_a), 32'd3);
      if (k == 39) chk("trg_c39_done", 32'(done_a), 32'd1);
    end
    // Trigger during the sequence is ignored
    do_reset();
    repeat (13) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("trg_c13_ignored", 32'(ch_a), 32'd0);
    repeat (12) step(1'b1, 1'b0);
`endif

    // Random trigger and reset traffic
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0));
    end

    // Reset has priority over trigger in DONE; initial delay honoured afterwards
    do_reset();
    repeat (25) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("prio_ch", 32'(ch_a), 32'd7);
    chk("prio_done", 32'(done_a), 32'd0);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1);
      if (k == 9)  chk("prio_c9_ch", 32'(ch_a), 32'd7);
      if (k == 10) chk("prio_c10_ch", 32'(ch_a), 32'd0);
    end

    // Long hold in DONE
    do_reset();
    repeat (1025) step(1'b1, 1'b0);
    chk("sat_ch", 32'(ch_a), 32'd7);
    chk("sat_done", 32'(done_a), 32'd1);
    chk("sat_b_ch", 32'(ch_b), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
